// File: rtl/spi_mst_if.sv
// spi_mst request/response bundle.
// o_rsp_retry_cnt exists only when SPI_MST_RETRY_EN is defined.
`timescale 1ns/1ps
interface spi_mst_if;
  logic       i_req;
  logic       i_wr;
  logic [6:0] i_addr;
  logic [7:0] i_wdata;
  logic       o_req_rdy;
  logic       o_rsp_vld;
  logic [7:0] o_rsp_rdata;
  logic       o_rsp_err;
  logic [1:0] o_rsp_err_code;
`ifdef SPI_MST_RETRY_EN
  logic [2:0] o_rsp_retry_cnt;
`endif

  modport master (
    output i_req,
    output i_wr,
    output i_addr,
    output i_wdata,
`ifdef SPI_MST_RETRY_EN
    input  o_rsp_retry_cnt,
`endif
    input  o_req_rdy,
    input  o_rsp_vld,
    input  o_rsp_rdata,
    input  o_rsp_err,
    input  o_rsp_err_code
  );

  modport slave (
    input  i_req,
    input  i_wr,
    input  i_addr,
    input  i_wdata,
`ifdef SPI_MST_RETRY_EN
    output o_rsp_retry_cnt,
`endif
    output o_req_rdy,
    output o_rsp_vld,
    output o_rsp_rdata,
    output o_rsp_err,
    output o_rsp_err_code
  );
endinterface

// File: rtl/spi_mst.sv
// SPI master for the 24-bit register-access frame (CMD + FETCH per access).
// Optional response retry: define SPI_MST_RETRY_EN.
`timescale 1ns/1ps
module spi_mst #(
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned FRM_BIT_NUM = 24
`ifdef SPI_MST_RETRY_EN
  ,
  parameter int unsigned RETRY_MAX   = 2
`endif
) (
  input  logic     i_spi_sclk,
  input  logic     i_rst_n,
  spi_mst_if.slave bus,
  output logic     o_spi_sclk,
  output logic     o_spi_csb,
  output logic     o_spi_mosi,
  input  logic     i_spi_miso
);

  localparam int unsigned BCW = 5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP1,
    FETCH,
    DONE,
    GAP2
  } st_e;

  st_e st_q;
  st_e st_d;

  logic           wr_q;
  logic [6:0]     addr_q;
  logic [BCW-1:0] bit_cnt;
  logic [7:0]     gap_cnt;
  logic [23:0]    tx_sr;
  logic [23:0]    rx_sr;
  logic           sclk_en;

  logic           req_rdy;
  logic           acc;
  logic           bit_last;
  logic           gap_last;
  logic           shift_st;
  logic           gap_st;
  logic           ld_cmd;
  logic           ld_fetch;
  logic           done;
  logic           rsp_fire;
  logic           retry_go;
  logic           retry_pend;

  logic [15:0]    cmd_hdr;
  logic [15:0]    fch_hdr;
  logic [7:0]     cmd_crc;
  logic [7:0]     fch_crc;
  logic [7:0]     rsp_crc;

  logic           crc_ok;
  logic           addr_ok;
  logic           type_ok;
  logic           chk_err;
  logic [1:0]     chk_code;

  logic           rsp_vld_q;
  logic [7:0]     rsp_rdata_q;
  logic           rsp_err_q;
  logic [1:0]     rsp_code_q;

  // CRC-8, poly x^8+x^2+x+1, init 0, MSB first, unrolled over 16 bits
  function automatic logic [7:0] crc16to8_parallel(
    input logic [15:0] d
  );
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign acc      = bus.i_req & req_rdy;
  assign bit_last = bit_cnt == BCW'(FRM_BIT_NUM - 1);
  assign gap_last = gap_cnt == 8'(GAP_CYC - 1);

`ifdef SPI_MST_RETRY_EN
  logic [7:0] wdata_q;
  logic [2:0] retry_cnt;
  logic [2:0] rsp_retry_q;

  assign retry_go = chk_err & (retry_cnt < 3'(RETRY_MAX));
  assign cmd_hdr  = acc ? {bus.i_wr, bus.i_addr, bus.i_wdata}
                        : {wr_q, addr_q, wdata_q};

  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdata_q     <= '0;
      retry_cnt   <= '0;
      retry_pend  <= 1'b0;
      rsp_retry_q <= '0;
    end else begin
      if (acc) begin
        wdata_q   <= bus.i_wdata;
        retry_cnt <= '0;
      end else if (done & retry_go) begin
        retry_cnt <= retry_cnt + 3'd1;
      end
      if (done & retry_go) begin
        retry_pend <= 1'b1;
      end else if (ld_cmd) begin
        retry_pend <= 1'b0;
      end
      if (rsp_fire) begin
        rsp_retry_q <= retry_cnt;
      end
    end
  end

  assign bus.o_rsp_retry_cnt = rsp_retry_q;
`else
  assign retry_go   = 1'b0;
  assign retry_pend = 1'b0;
  assign cmd_hdr    = {bus.i_wr, bus.i_addr, bus.i_wdata};
`endif

  assign fch_hdr = {1'b0, addr_q, 8'h00};
  assign cmd_crc = crc16to8_parallel(cmd_hdr);
  assign fch_crc = crc16to8_parallel(fch_hdr);
  assign rsp_crc = crc16to8_parallel(rx_sr[23:8]);

  assign crc_ok  = rsp_crc == rx_sr[7:0];
  assign addr_ok = rx_sr[22:16] == addr_q;
  assign type_ok = rx_sr[23] == wr_q;

  always_comb begin
    chk_code = 2'd0;
    priority case (1'b1)
      !crc_ok:  chk_code = 2'd1;
      !addr_ok: chk_code = 2'd2;
      !type_ok: chk_code = 2'd3;
      default:  chk_code = 2'd0;
    endcase
  end

  assign chk_err = |chk_code;

  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (acc)      st_d = CMD;
      CMD:     if (bit_last) st_d = GAP1;
      GAP1:    if (gap_last) st_d = FETCH;
      FETCH:   if (bit_last) st_d = DONE;
      DONE:    st_d = GAP2;
      GAP2: begin
        if (gap_last) begin
          st_d = retry_pend ? CMD : IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    req_rdy  = 1'b0;
    shift_st = 1'b0;
    gap_st   = 1'b0;
    ld_fetch = 1'b0;
    done     = 1'b0;
    unique case (st_q)
      IDLE:  req_rdy  = 1'b1;
      CMD:   shift_st = 1'b1;
      FETCH: shift_st = 1'b1;
      DONE:  done     = 1'b1;
      GAP1: begin
        gap_st   = 1'b1;
        ld_fetch = gap_last;
      end
      GAP2:  gap_st   = 1'b1;
      default: ;
    endcase
  end

  assign ld_cmd   = acc | ((st_q == GAP2) & gap_last & retry_pend);
  assign rsp_fire = done & ~retry_go;

  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (acc) begin
        wr_q   <= bus.i_wr;
        addr_q <= bus.i_addr;
      end

      if (ld_cmd) begin
        tx_sr <= {cmd_hdr, cmd_crc};
      end else if (ld_fetch) begin
        tx_sr <= {fch_hdr, fch_crc};
      end else if (shift_st) begin
        tx_sr <= {tx_sr[22:0], 1'b0};
      end

      if (st_q == FETCH) begin
        rx_sr <= {rx_sr[22:0], i_spi_miso};
      end

      if (shift_st && !bit_last) begin
        bit_cnt <= bit_cnt + BCW'(1);
      end else begin
        bit_cnt <= '0;
      end

      if (gap_st && !gap_last) begin
        gap_cnt <= gap_cnt + 8'd1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= '0;
    end else begin
      rsp_vld_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_rdata_q <= rx_sr[15:8];
        rsp_err_q   <= chk_err;
        rsp_code_q  <= chk_code;
      end
    end
  end

  assign bus.o_req_rdy      = req_rdy;
  assign bus.o_rsp_vld      = rsp_vld_q;
  assign bus.o_rsp_rdata    = rsp_rdata_q;
  assign bus.o_rsp_err      = rsp_err_q;
  assign bus.o_rsp_err_code = rsp_code_q;

  // Pins launch on negedge so the slave sees them stable at its posedge.
  always_ff @(negedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_spi_csb  <= 1'b1;
      sclk_en    <= 1'b0;
      o_spi_mosi <= 1'b0;
    end else begin
      o_spi_csb  <= ~shift_st;
      sclk_en    <= shift_st;
      o_spi_mosi <= shift_st & tx_sr[23];
    end
  end

  assign o_spi_sclk = i_spi_sclk & sclk_en;

endmodule

// File: tb/tb_spi_mst.sv
// Self-checking bench for spi_mst with a behavioural SPI slave.
// Retry-specific checks are compiled in with SPI_MST_RETRY_EN.
`timescale 1ns/1ps
module tb_spi_mst;

  localparam int GAP  = 16;
  localparam int RMAX = 2;
  localparam int NV   = 9;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [23:0] rsp;
    logic [7:0]  rdata;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk;
  logic csb;
  logic mosi;
  logic miso  = 1'b0;

  spi_mst_if bus ();

  spi_mst #(
    .GAP_CYC     (GAP),
    .FRM_BIT_NUM (24)
  ) dut (
    .i_spi_sclk (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_spi_sclk (sclk),
    .o_spi_csb  (csb),
    .o_spi_mosi (mosi),
    .i_spi_miso (miso)
  );

  always #5 clk = ~clk;

  int          n_chk     = 0;
  int          n_fail    = 0;
  int          bitn      = 0;
  int          hi_cnt    = 0;
  int          gate_viol = 0;
  int          vld_cnt   = 0;
  int          acc_cnt   = 0;
  logic [23:0] cap       = '0;
  logic [23:0] rsp_frame = '0;
  logic [23:0] frm_q[$];
  int          pls_q[$];
  int          gap_q[$];
  vec_t        vecs[NV];

  // Reference CRC as polynomial long division of d*x^8 by 0x107.
  function automatic logic [7:0] ref_crc(input logic [15:0] d);
    logic [23:0] r;
    r = {d, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [23:0] mk(
    input logic f, input logic [6:0] a, input logic [7:0] dd
  );
    return {f, a, dd, ref_crc({f, a, dd})};
  endfunction

  function automatic int exp_lat(input logic err);
    int l;
    l = 49 + GAP;
`ifdef SPI_MST_RETRY_EN
    if (err) l = l + RMAX * (49 + 2 * GAP);
`endif
    return l;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Slave model: capture MOSI on sclk, frame closes on csb rise.
  always @(posedge sclk or posedge csb) begin
    if (csb) begin
      frm_q.push_back(cap);
      pls_q.push_back(bitn);
      cap  = '0;
      bitn = 0;
    end else begin
      cap = {cap[22:0], mosi};
      bitn++;
    end
  end

  always @(posedge sclk) if (csb) gate_viol++;

  always @(posedge clk or negedge csb) begin
    if (csb) begin
      hi_cnt++;
    end else if (hi_cnt != 0) begin
      gap_q.push_back(hi_cnt);
      hi_cnt = 0;
    end
  end

  always @(negedge clk) begin
    miso <= (bitn < 24) ? rsp_frame[23 - bitn] : 1'b0;
  end

  always @(negedge clk) if (bus.o_rsp_vld) vld_cnt++;
  always @(posedge clk) if (bus.i_req && bus.o_req_rdy) acc_cnt++;

  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_req_rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy_wait", 32'(bus.o_req_rdy), 32'd1);
  endtask

  task automatic wait_vld(output int lat);
    lat = -1;
    for (int k = 1; k < 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_rsp_vld) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_txn(
    input logic wr, input logic [6:0] a, input logic [7:0] wd,
    output int lat
  );
    frm_q.delete();
    pls_q.delete();
    gap_q.delete();
    wait_rdy();
    bus.i_req   = 1'b1;
    bus.i_wr    = wr;
    bus.i_addr  = a;
    bus.i_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0;
    wait_vld(lat);
  endtask

  task automatic check_vec(input string nm, input vec_t v, input int lat);
    logic [23:0] ecmd;
    logic [23:0] efch;
    int          nfr;
    ecmd = mk(v.wr, v.addr, v.wdata);
    efch = mk(1'b0, v.addr, 8'h00);
    nfr  = 2;
`ifdef SPI_MST_RETRY_EN
    if (v.err) nfr = 2 * (RMAX + 1);
    chk({nm, " retry_cnt"}, 32'(bus.o_rsp_retry_cnt),
        v.err ? 32'(RMAX) : 32'd0);
`endif
    chk({nm, " latency"}, lat, exp_lat(v.err));
    chk({nm, " rdata"}, 32'(bus.o_rsp_rdata), 32'(v.rdata));
    chk({nm, " err"}, 32'(bus.o_rsp_err), 32'(v.err));
    chk({nm, " code"}, 32'(bus.o_rsp_err_code), 32'(v.code));
    chk({nm, " n_frames"}, frm_q.size(), nfr);
    chk({nm, " cmd_frame"},
        (frm_q.size() > 0) ? 32'(frm_q[0]) : 32'hffff_ffff, 32'(ecmd));
    chk({nm, " fetch_frame"},
        (frm_q.size() > 1) ? 32'(frm_q[1]) : 32'hffff_ffff, 32'(efch));
    chk({nm, " cmd_pulses"},
        (pls_q.size() > 0) ? pls_q[0] : -1, 24);
    chk({nm, " fetch_pulses"},
        (pls_q.size() > 1) ? pls_q[1] : -1, 24);
    chk({nm, " csb_gap"},
        (gap_q.size() > 1) ? gap_q[1] : -1, GAP);
    @(negedge clk);
    chk({nm, " vld_pulse"}, 32'(bus.o_rsp_vld), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int m;
    int a0;
    int vs;

    bus.i_req   = 1'b0;
    bus.i_wr    = 1'b0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;

    vecs[0] = '{1'b1, 7'h05, 8'hA5, mk(1'b1, 7'h05, 8'hA5),
                8'hA5, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 7'h12, 8'h00, mk(1'b0, 7'h12, 8'h3C),
                8'h3C, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 7'h12, 8'h00, mk(1'b0, 7'h12, 8'h3C) ^ 24'h8,
                8'h3C, 1'b1, 2'd1};
    vecs[3] = '{1'b0, 7'h12, 8'h00, mk(1'b0, 7'h13, 8'h3C),
                8'h3C, 1'b1, 2'd2};
    vecs[4] = '{1'b0, 7'h12, 8'h00, mk(1'b1, 7'h12, 8'h3C),
                8'h3C, 1'b1, 2'd3};
    vecs[5] = '{1'b0, 7'h12, 8'h00, mk(1'b0, 7'h13, 8'h3C) ^ 24'h8,
                8'h3C, 1'b1, 2'd1};
    vecs[6] = '{1'b1, 7'h7F, 8'h00, mk(1'b1, 7'h7F, 8'h00),
                8'h00, 1'b0, 2'd0};
    vecs[7] = '{1'b1, 7'h12, 8'h5A, mk(1'b0, 7'h12, 8'h5A),
                8'h5A, 1'b1, 2'd3};
    vecs[8] = '{1'b0, 7'h00, 8'h00, mk(1'b0, 7'h00, 8'hFF),
                8'hFF, 1'b0, 2'd0};

    repeat (3) @(negedge clk);
    chk("rst req_rdy", 32'(bus.o_req_rdy), 32'd1);
    chk("rst rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
    chk("rst rdata", 32'(bus.o_rsp_rdata), 32'd0);
    chk("rst err", 32'(bus.o_rsp_err), 32'd0);
    chk("rst code", 32'(bus.o_rsp_err_code), 32'd0);
    chk("rst csb", 32'(csb), 32'd1);
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst mosi", 32'(mosi), 32'd0);
`ifdef SPI_MST_RETRY_EN
    chk("rst retry_cnt", 32'(bus.o_rsp_retry_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle csb", 32'(csb), 32'd1);

    for (int i = 0; i < NV; i++) begin
      rsp_frame = vecs[i].rsp;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      check_vec($sformatf("vec%0d", i), vecs[i], lat);
    end

    // Request held high across a whole transaction.
    rsp_frame = mk(1'b1, 7'h05, 8'hA5);
    a0 = acc_cnt;
    wait_rdy();
    bus.i_req   = 1'b1;
    bus.i_wr    = 1'b1;
    bus.i_addr  = 7'h05;
    bus.i_wdata = 8'hA5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_rsp_vld && n < 300);
    chk("busy vld_seen", 32'(bus.o_rsp_vld), 32'd1);
    chk("busy one_accept", acc_cnt - a0, 1);
    m = 0;
    while (!bus.o_req_rdy && m < 100) begin
      @(negedge clk);
      m++;
    end
    chk("busy rdy_delay", m, GAP);
    chk("busy no_early_accept", acc_cnt - a0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0;
    chk("busy b2b_accept", acc_cnt - a0, 2);
    wait_vld(lat);
    chk("busy b2b latency", lat, 49 + GAP);
    chk("busy b2b err", 32'(bus.o_rsp_err), 32'd0);

    // Reset in the middle of a CMD frame.
    wait_rdy();
    bus.i_req   = 1'b1;
    bus.i_wr    = 1'b1;
    bus.i_addr  = 7'h33;
    bus.i_wdata = 8'h44;
    @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0;
    n = 0;
    while (bitn != 10 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst bit10", bitn, 10);
    chk("midrst sclk_hi_before", 32'(sclk), 32'd1);
    vs = vld_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst csb", 32'(csb), 32'd1);
    chk("midrst sclk", 32'(sclk), 32'd0);
    chk("midrst req_rdy", 32'(bus.o_req_rdy), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst no_vld", vld_cnt, vs);
    rsp_frame = vecs[0].rsp;
    run_txn(vecs[0].wr, vecs[0].addr, vecs[0].wdata, lat);
    check_vec("post_rst", vecs[0], lat);

    chk("sclk_gated_by_csb", gate_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
